output_port_reader: RTL and testbench
=====================================

Name: output_port_reader

Overview:
- Avalon-MM read-side slave that drains the four per-port output RAMs of the switch back to the host.
- It is the counterpart of the input-side write slave on the same bus and address space.
- The switch fabric writes the output RAMs and exports its write pointers. This block owns the read pointers.
- Each port prefetches its head word into a holding register, so a host read of a port pops one packet word.

Parameters:
NPORTS, 4, number of output ports/RAMs
AW, 12, output RAM address width (4096 words)
DW, 32, data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
chipselect  in  1  Avalon slave select
read  in  1  Avalon read strobe
write  in  1  Avalon write strobe
address  in  4  Avalon word address
writedata  in  32  Avalon write data (content ignored; address-only commands)
readdata  out  32  Avalon read data, fixed read latency 1
out_wraddr  in  NPORTS*AW  fabric write pointers; port n at [AW*n+AW-1:AW*n]
out_q  in  NPORTS*DW  output RAM read data; port n at [DW*n+DW-1:DW*n]
out_rdaddr  out  NPORTS*AW  output RAM read addresses (= per-port rd pointer)
out_rden  out  NPORTS  output RAM read enables

Behaviour:
- Reset (asynchronous, active-low) clears everything: readdata=0, out_rden=0, out_rdaddr=0, all heads invalid, underflow bits 0, all FSMs IDLE. It takes effect mid-fetch; any in-flight q is discarded.
- RAM contract: the RAM samples rdaddress/rden on a clk edge and presents q from the following edge onward.
- Per-port FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if wr!=rd go to ISSUE; otherwise stay.
  - ISSUE: out_rden[n]=1, decoded from the state register only. Always go to WAIT.
  - WAIT: capture head<=q, rd<=rd+1 (mod 2^AW), head_valid=1, go to HOLD.
  - HOLD: hold head until popped. On pop, head_valid=0; go to ISSUE if wr!=rd (using the post-increment rd), else IDLE.
- Pop-to-next-head-valid latency is 3 cycles. The host must poll status; there is no waitrequest.
- Occupancy[n] = (wr - rd) mod 2^AW + head_valid. It is (AW+1) bits, zero-extended on readback.
- The fabric never holds more than 2^AW-1 unread words per port; that case is not detected here.
- Read map (readdata registered, valid the cycle after chipselect&read):
  - addr 0..3: if head_valid[n], return head and pop. Else return 0, do not pop, and set underflow[n] (sticky).
  - addr 4: status. [3:0]=head_valid, [7:4]=underflow, [31:8]=0.
  - addr 5..8: occupancy of port addr-5.
  - any other address: 0, no side effect.
- readdata holds its last value when there is no read.
- Write map; data is ignored and the command takes effect at the sampling edge:
  - addr 12: clear the underflow bits.
  - addr 13: pointer clear. All rd pointers to 0, heads invalid, underflow cleared, FSMs to IDLE; an in-flight fetch is aborted.
  - Address 13 is the same command the input-side slave and fabric use to zero their pointers. If out_wraddr is nonzero after a clear, the FSM refetches from address 0.
  - Writes to other addresses, including 0..3, 14 and 15, are ignored by this block.
- Read and write never coincide (Avalon); if both assert, write wins and readdata is 0.
- Wrap: rd increments modulo 2^AW. Empty/non-empty is judged only by wr!=rd plus head_valid.

Decomposition:
- Package switch_pkg holds:
  - NPORTS, AW, DW;
  - address constants (ADDR_STATUS=4, ADDR_OCC_BASE=5, ADDR_CLR_UFL=12, ADDR_CLR_PTR=13);
  - typedef enum fetch_state_t {IDLE, ISSUE, WAIT, HOLD}.
- Sub-module out_port_fetcher, instantiated NPORTS times:
  - contents: FSM, rd pointer, head register, head_valid, occupancy;
  - inputs: pop, clr, wraddr, q.
- The top level holds the Avalon decode, underflow bits and the readdata register.

Test Plan:
- Reset: assert reset low mid-run -> readdata=0, out_rden=0, out_rdaddr=0; status read (addr 4) = 0x0.
- Basic drain: RAM0 words 0xA,0xB,0xC at 0..2, out_wraddr[0] 0->3.
  - After 3 cycles, status=0x1 and addr 5 reads 3.
  - Reading addr 0 (with ≥3-cycle gaps) returns 0xA, 0xB, 0xC.
  - Then addr 5 reads 0 and status reads 0x0.
- Underflow: read addr 2 with port 2 empty -> readdata=0, status=0x40. Write addr 12 -> status=0x0.
- Back-to-back: port 1 holds 0x11,0x22; reads of addr 1 on consecutive cycles -> 0x11, then 0 with status bit5 set. Three cycles later a read returns 0x22.
- Wrap: rd[3]=4095, wr[3]=1, RAM3[4095]=0xF0, RAM3[0]=0xF1 -> addr 8 reads 2; pops return 0xF0, 0xF1; out_rdaddr[3] ends at 1.
- Clear during fetch: write addr 13 while port 0 is in WAIT -> next cycle head invalid, out_rdaddr[0]=0, out_rden[0]=0, status=0x0. With out_wraddr[0]=0, the port stays IDLE.

Source files
------------

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_pkg
// Purpose  : Shared sizes, Avalon register map and the per-port fetch state
//            encoding for the switch output-side read slave.
// Contents : NPORTS / AW / DW, address constants, fetch_state_t.
// Revision : 1.0 - initial release
// ============================================================================
package switch_pkg;

  localparam int NPORTS = 4;   // output ports / RAMs
  localparam int AW     = 12;  // output RAM address width
  localparam int DW     = 32;  // data width

  // Avalon word addresses (reads 0..3 pop a port head)
  localparam logic [3:0] ADDR_STATUS   = 4'd4;
  localparam logic [3:0] ADDR_OCC_BASE = 4'd5;
  localparam logic [3:0] ADDR_CLR_UFL  = 4'd12;
  localparam logic [3:0] ADDR_CLR_PTR  = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/output_port_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : output_port_reader_if
// Purpose  : Avalon-MM slave bus plus the output-RAM read side of the switch.
// Signals  : chipselect/read/write/address/writedata/readdata (Avalon),
//            out_wraddr (fabric write pointers), out_q (RAM data),
//            out_rdaddr/out_rden (RAM read controls).
// Modports : slave  - the reader block
//            master - host and RAM/fabric side
// Revision : 1.0 - initial release
// ============================================================================
interface output_port_reader_if;
  import switch_pkg::*;

  logic                 chipselect;
  logic                 read;
  logic                 write;
  logic [3:0]           address;
  logic [DW-1:0]        writedata;
  logic [DW-1:0]        readdata;
  logic [NPORTS*AW-1:0] out_wraddr;
  logic [NPORTS*DW-1:0] out_q;
  logic [NPORTS*AW-1:0] out_rdaddr;
  logic [NPORTS-1:0]    out_rden;

  modport slave (
    input  chipselect, read, write, address, writedata, out_wraddr, out_q,
    output readdata, out_rdaddr, out_rden
  );

  modport master (
    output chipselect, read, write, address, writedata, out_wraddr, out_q,
    input  readdata, out_rdaddr, out_rden
  );

endinterface
`default_nettype wire

// File: rtl/out_port_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : out_port_fetcher
// Purpose  : Owns one output port's read pointer and prefetches the head word
//            of its output RAM into a holding register.
// Ports    : clk, reset (async active-low)
//            pop        - host consumed the head word
//            clr        - pointer clear (rd=0, head dropped, FSM to IDLE)
//            wraddr     - fabric write pointer
//            q          - RAM read data
//            rdaddr     - RAM read address (= rd pointer)
//            rden       - RAM read enable
//            head       - holding register
//            head_valid - holding register is full
//            occupancy  - unread words including the head (AW+1 bits)
// Revision : 1.0 - initial release
// ============================================================================
module out_port_fetcher
  import switch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          pop,
  input  logic          clr,
  input  logic [AW-1:0] wraddr,
  input  logic [DW-1:0] q,
  output logic [AW-1:0] rdaddr,
  output logic          rden,
  output logic [DW-1:0] head,
  output logic          head_valid,
  output logic [AW:0]   occupancy
);

  fetch_state_t  state, state_next;
  logic [AW-1:0] rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // rd is already advanced when HOLD decides whether to refetch.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (wraddr != rd) state_next = ISSUE;
        ISSUE:   state_next = WAIT;
        WAIT:    state_next = HOLD;
        HOLD:    if (pop) state_next = (wraddr != rd) ? ISSUE : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Decoded purely from the state register so the RAM sees a glitch-free
  // enable; a clear issued in ISSUE lets the read go out but its q is ignored.
  assign rden = (state == ISSUE);

  // q is valid during WAIT (RAM sampled the address at the end of ISSUE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd         <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else if (clr) begin
      rd         <= '0;
      head_valid <= 1'b0;
    end else if (state == WAIT) begin
      head       <= q;
      rd         <= rd + 1'b1;
      head_valid <= 1'b1;
    end else if (state == HOLD && pop) begin
      head_valid <= 1'b0;
    end
  end

  assign rdaddr    = rd;
  assign occupancy = {1'b0, wraddr - rd} + {{AW{1'b0}}, head_valid};

endmodule
`default_nettype wire

// File: rtl/output_port_reader.sv
`default_nettype none
// ============================================================================
// Module   : output_port_reader
// Purpose  : Avalon-MM read slave that drains the switch output RAMs to the
//            host. Reads 0..3 pop a port head, 4 is status, 5..8 occupancy;
//            writes 12 clear underflow, 13 clear pointers.
// Ports    : clk   - system clock
//            reset - asynchronous active-low reset
//            bus   - output_port_reader_if.slave (Avalon + output RAM side)
// Revision : 1.0 - initial release
// ============================================================================
module output_port_reader
  import switch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output_port_reader_if.slave  bus
);

  logic              rd_req, wr_req, collide, clr_ptr, clr_ufl;
  logic [NPORTS-1:0] pop, head_valid, underflow, ufl_set;
  logic [DW-1:0]     head [NPORTS];
  logic [AW:0]       occ  [NPORTS];
  logic [DW-1:0]     rd_mux;
  logic              unused_writedata;

  // Commands are address-only; the data word carries nothing.
  assign unused_writedata = ^bus.writedata;

  // A write always wins over a simultaneous read.
  assign collide = bus.chipselect & bus.read & bus.write;
  assign rd_req  = bus.chipselect & bus.read & ~bus.write;
  assign wr_req  = bus.chipselect & bus.write;
  assign clr_ptr = wr_req && (bus.address == ADDR_CLR_PTR);
  assign clr_ufl = wr_req && (bus.address == ADDR_CLR_UFL);

  generate
    for (genvar g = 0; g < NPORTS; g++) begin : g_port
      out_port_fetcher u_fetch (
        .clk        (clk),
        .reset      (reset),
        .pop        (pop[g]),
        .clr        (clr_ptr),
        .wraddr     (bus.out_wraddr[AW*g +: AW]),
        .q          (bus.out_q[DW*g +: DW]),
        .rdaddr     (bus.out_rdaddr[AW*g +: AW]),
        .rden       (bus.out_rden[g]),
        .head       (head[g]),
        .head_valid (head_valid[g]),
        .occupancy  (occ[g])
      );
    end
  endgenerate

  // A port read pops only when a head is present; otherwise it flags underflow.
  always_comb begin
    pop     = '0;
    ufl_set = '0;
    for (int n = 0; n < NPORTS; n++) begin
      if (rd_req && bus.address == 4'(n)) begin
        pop[n]     = head_valid[n];
        ufl_set[n] = ~head_valid[n];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 underflow <= '0;
    else if (clr_ufl | clr_ptr) underflow <= '0;
    else                        underflow <= underflow | ufl_set;
  end

  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NPORTS; n++) begin
      if (bus.address == 4'(n) && head_valid[n]) rd_mux = head[n];
      if (bus.address == ADDR_OCC_BASE + 4'(n))  rd_mux[AW:0] = occ[n];
    end
    if (bus.address == ADDR_STATUS) begin
      rd_mux[NPORTS-1:0]        = head_valid;
      rd_mux[2*NPORTS-1:NPORTS] = underflow;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       bus.readdata <= '0;
    else if (collide) bus.readdata <= '0;
    else if (rd_req)  bus.readdata <= rd_mux;
  end

endmodule
`default_nettype wire

// File: tb/tb_output_port_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_port_reader
// Purpose  : Self-checking bench for output_port_reader with a behavioural
//            output RAM per port (q registered one edge after rdaddr/rden).
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_port_reader;
  import switch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  output_port_reader_if bus ();

  output_port_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Output RAM model
  logic [DW-1:0]        mem [NPORTS][1<<AW];
  logic [NPORTS*DW-1:0] q_r = '0;
  assign bus.out_q = q_r;

  always @(posedge clk) begin
    for (int n = 0; n < NPORTS; n++)
      if (bus.out_rden[n]) q_r[n*DW +: DW] <= mem[n][bus.out_rdaddr[n*AW +: AW]];
  end

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    int          gap;
    logic [31:0] exp;
    bit          chk;
    string       name;
  } vec_t;

  localparam int NV = 17;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    d              = bus.readdata;
  endtask

  task automatic do_write(input logic [3:0] a);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = $urandom;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic set_wr(input int port, input int val);
    bus.out_wraddr[port*AW +: AW] = AW'(val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl [NV];
    logic [31:0] d;
    int          bad;

    reset          = 1'b0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.out_wraddr = '0;

    // ---------------- reset state
    repeat (2) @(negedge clk);
    check("rst_readdata", bus.readdata, 0);
    check("rst_rden", bus.out_rden, 0);
    check("rst_rdaddr", bus.out_rdaddr, 0);
    reset = 1'b1;
    @(negedge clk);

    // ---------------- basic drain, underflow, map corners
    tbl[0]  = '{0, 4'd4,  3, 32'h1,  1, "status_fill"};
    tbl[1]  = '{0, 4'd5,  0, 32'd3,  1, "occ0_full"};
    tbl[2]  = '{0, 4'd6,  0, 32'd0,  1, "occ1_empty"};
    tbl[3]  = '{0, 4'd0,  0, 32'hA,  1, "pop_a"};
    tbl[4]  = '{0, 4'd5,  3, 32'd2,  1, "occ0_mid"};
    tbl[5]  = '{0, 4'd0,  0, 32'hB,  1, "pop_b"};
    tbl[6]  = '{0, 4'd0,  3, 32'hC,  1, "pop_c"};
    tbl[7]  = '{0, 4'd5,  3, 32'd0,  1, "occ0_drained"};
    tbl[8]  = '{0, 4'd4,  0, 32'h0,  1, "status_drained"};
    tbl[9]  = '{0, 4'd2,  0, 32'h0,  1, "underflow_rd"};
    tbl[10] = '{0, 4'd4,  0, 32'h40, 1, "status_ufl"};
    tbl[11] = '{1, 4'd0,  0, 32'h40, 1, "hold_on_write0"};
    tbl[12] = '{0, 4'd4,  0, 32'h40, 1, "ufl_sticky"};
    tbl[13] = '{1, 4'd12, 0, 32'h40, 1, "hold_on_clr_ufl"};
    tbl[14] = '{0, 4'd4,  0, 32'h0,  1, "status_ufl_clr"};
    tbl[15] = '{0, 4'd9,  0, 32'h0,  1, "unmapped_9"};
    tbl[16] = '{0, 4'd15, 0, 32'h0,  1, "unmapped_15"};

    mem[0][0] = 32'hA;
    mem[0][1] = 32'hB;
    mem[0][2] = 32'hC;
    set_wr(0, 3);
    for (int i = 0; i < NV; i++) begin
      repeat (tbl[i].gap) @(negedge clk);
      if (tbl[i].is_wr) begin
        do_write(tbl[i].addr);
        d = bus.readdata;
      end else begin
        do_read(tbl[i].addr, d);
      end
      if (tbl[i].chk) check(tbl[i].name, d, tbl[i].exp);
    end

    // ---------------- back-to-back pops on port 1
    mem[1][0] = 32'h11;
    mem[1][1] = 32'h22;
    set_wr(1, 2);
    repeat (3) @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 4'd1;
    @(negedge clk);
    check("b2b_first", bus.readdata, 32'h11);
    @(negedge clk);
    check("b2b_second", bus.readdata, 32'h0);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    do_read(4'd4, d);
    check("b2b_status", d, 32'h20);
    @(negedge clk);
    do_read(4'd1, d);
    check("b2b_refetch", d, 32'h22);
    repeat (2) @(negedge clk);
    check("hold_idle", bus.readdata, 32'h22);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = ADDR_CLR_UFL;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    check("collide_zero", bus.readdata, 32'h0);
    do_read(4'd4, d);
    check("collide_clr_ufl", d, 32'h0);

    // ---------------- pointer clear during a fetch
    bus.out_wraddr = '0;
    do_write(ADDR_CLR_PTR);
    mem[0][0] = 32'h77;
    set_wr(0, 1);
    @(negedge clk);
    check("fetch_issue_rden", bus.out_rden[0], 1);
    @(negedge clk);
    check("fetch_wait_rden", bus.out_rden[0], 0);
    bus.out_wraddr = '0;
    do_write(ADDR_CLR_PTR);
    check("clr_rdaddr0", bus.out_rdaddr[AW-1:0], 0);
    check("clr_rden0", bus.out_rden[0], 0);
    do_read(4'd4, d);
    check("clr_status", d, 32'h0);
    repeat (4) @(negedge clk);
    check("clr_stays_idle", bus.out_rden, 0);
    do_read(4'd5, d);
    check("clr_occ0", d, 32'h0);

    // ---------------- wrap on port 3: walk rd up to 4095 first
    for (int i = 0; i < (1 << AW); i++) mem[3][i] = 32'h3000_0000 + i;
    set_wr(3, 4095);
    bad = 0;
    for (int i = 0; i < 4095; i++) begin
      repeat (3) @(negedge clk);
      do_read(4'd3, d);
      if (d !== 32'h3000_0000 + i) bad++;
    end
    check("walk_mismatches", bad, 0);
    check("walk_rdaddr3", bus.out_rdaddr[3*AW +: AW], 4095);
    mem[3][4095] = 32'hF0;
    mem[3][0]    = 32'hF1;
    set_wr(3, 1);
    do_read(4'd8, d);
    check("wrap_occ3", d, 32'd2);
    repeat (3) @(negedge clk);
    do_read(4'd3, d);
    check("wrap_pop_f0", d, 32'hF0);
    repeat (3) @(negedge clk);
    do_read(4'd3, d);
    check("wrap_pop_f1", d, 32'hF1);
    check("wrap_rdaddr3", bus.out_rdaddr[3*AW +: AW], 1);
    do_read(4'd8, d);
    check("wrap_occ3_empty", d, 32'd0);

    // ---------------- asynchronous reset in the middle of a refetch
    mem[1][0] = 32'h99;
    mem[1][1] = 32'h9A;
    set_wr(1, 2);
    repeat (3) @(negedge clk);
    do_read(4'd4, d);
    check("pre_rst_status", d, 32'h2);
    do_read(4'd1, d);
    check("pre_rst_pop", d, 32'h99);
    check("pre_rst_rden1", bus.out_rden[1], 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_readdata", bus.readdata, 0);
    check("mid_rst_rden", bus.out_rden, 0);
    check("mid_rst_rdaddr", bus.out_rdaddr, 0);
    bus.out_wraddr = '0;
    @(negedge clk);
    reset = 1'b1;
    do_read(4'd4, d);
    check("post_rst_status", d, 32'h0);
    do_read(4'd6, d);
    check("post_rst_occ1", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
